// File: rtl/tree_mac_accum.sv
// Streaming dot-product engine: per-beat multiply, pipelined TREE_BASE-ary adder
// tree, and a multi-beat accumulator closed by in_last, with valid/ready stall.
`timescale 1ns/1ps

module tree_mac_accum #(
  parameter int DATA_WIDTH      = 8,
  parameter int DATA_LENGTH     = 64,
  parameter int TREE_BASE       = 2,
  parameter int ACC_WIDTH       = 32,
  parameter int ADDRESS_WIDTH_I = 8,
  parameter int ADDRESS_WIDTH_K = 8,
  parameter int SIGNED          = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_val,
  output logic                            in_rdy,
  input  logic                            in_last,
  input  logic [DATA_WIDTH*DATA_LENGTH-1:0] row,
  input  logic [DATA_WIDTH*DATA_LENGTH-1:0] col,
  input  logic [ADDRESS_WIDTH_I-1:0]      addr_i_in,
  input  logic [ADDRESS_WIDTH_K-1:0]      addr_k_in,
  output logic                            out_val,
  input  logic                            out_rdy,
  output logic [ACC_WIDTH-1:0]            sum_out,
  output logic [ADDRESS_WIDTH_I-1:0]      addr_i_out,
  output logic [ADDRESS_WIDTH_K-1:0]      addr_k_out,
  output logic [15:0]                     beat_cnt_out
);

  function automatic int ceil_log(input int n, input int b);
    int l;
    int p;
    l = 0;
    p = 1;
    while (p < n) begin
      p = p * b;
      l = l + 1;
    end
    return l;
  endfunction

  function automatic int ipow(input int b, input int e);
    int p;
    p = 1;
    for (int i = 0; i < e; i++) p = p * b;
    return p;
  endfunction

  localparam int LEVELS = ceil_log(DATA_LENGTH, TREE_BASE);
  localparam int N_PAD  = ipow(TREE_BASE, LEVELS);
  localparam int PW     = 2 * DATA_WIDTH;

  // Full-width product, sign- or zero-extended to the accumulator width.
  function automatic logic [ACC_WIDTH-1:0] mul_ext(input logic [DATA_WIDTH-1:0] a,
                                                  input logic [DATA_WIDTH-1:0] b);
    logic signed [PW-1:0] sa;
    logic signed [PW-1:0] sb;
    logic        [PW-1:0] ua;
    logic        [PW-1:0] ub;
    if (SIGNED != 0) begin
      sa = PW'($signed(a));
      sb = PW'($signed(b));
      return ACC_WIDTH'(sa * sb);
    end else begin
      ua = PW'(a);
      ub = PW'(b);
      return ACC_WIDTH'(ua * ub);
    end
  endfunction

  logic en;
  assign en     = !out_val || out_rdy;
  assign in_rdy = en;

  // S0 input register
  logic                             s0_v;
  logic                             s0_last;
  logic [DATA_WIDTH*DATA_LENGTH-1:0] s0_row;
  logic [DATA_WIDTH*DATA_LENGTH-1:0] s0_col;
  logic [ADDRESS_WIDTH_I-1:0]       s0_ai;
  logic [ADDRESS_WIDTH_K-1:0]       s0_ak;

  // Index 0 is the multiply stage S1; index l is tree level l.
  logic                       p_v    [0:LEVELS];
  logic                       p_last [0:LEVELS];
  logic [ADDRESS_WIDTH_I-1:0] p_ai   [0:LEVELS];
  logic [ADDRESS_WIDTH_K-1:0] p_ak   [0:LEVELS];
  logic [ACC_WIDTH-1:0]       tree_q [0:LEVELS][0:N_PAD-1];
  logic [ACC_WIDTH-1:0]       tree_d [0:LEVELS][0:N_PAD-1];

  logic [ACC_WIDTH-1:0] acc;
  logic [15:0]          bc;
  logic [15:0]          bc_inc;
  logic [ACC_WIDTH-1:0] tree_sum;

  assign tree_sum = tree_q[LEVELS][0];
  assign bc_inc   = (bc == 16'hFFFF) ? bc : bc + 16'd1;

  always_comb begin
    // NOTE: every entry gets a default before the loops so no path leaves tree_d unassigned (no latch).
    for (int l = 0; l <= LEVELS; l++)
      for (int j = 0; j < N_PAD; j++)
        tree_d[l][j] = '0;
    for (int e = 0; e < DATA_LENGTH; e++)
      tree_d[0][e] = mul_ext(s0_row[e*DATA_WIDTH +: DATA_WIDTH],
                             s0_col[e*DATA_WIDTH +: DATA_WIDTH]);
    // Entries past a level's live width stay zero, so padding never leaks into the sum.
    for (int l = 1; l <= LEVELS; l++)
      for (int j = 0; j < N_PAD / TREE_BASE; j++)
        for (int m = 0; m < TREE_BASE; m++)
          tree_d[l][j] = tree_d[l][j] + tree_q[l-1][j*TREE_BASE + m];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s0_v    <= 1'b0;
      s0_last <= 1'b0;
      s0_row  <= '0;
      s0_col  <= '0;
      s0_ai   <= '0;
      s0_ak   <= '0;
      // NOTE: the tree registers are reset too; the array is small and it keeps X out of the adders.
      for (int l = 0; l <= LEVELS; l++) begin
        p_v[l]    <= 1'b0;
        p_last[l] <= 1'b0;
        p_ai[l]   <= '0;
        p_ak[l]   <= '0;
        for (int j = 0; j < N_PAD; j++) tree_q[l][j] <= '0;
      end
      acc          <= '0;
      bc           <= '0;
      out_val      <= 1'b0;
      sum_out      <= '0;
      beat_cnt_out <= '0;
      addr_i_out   <= '0;
      addr_k_out   <= '0;
    end else if (en) begin
      // NOTE: non-blocking updates so every stage samples its predecessor's pre-edge value.
      s0_v    <= in_val;
      s0_last <= in_last;
      s0_row  <= row;
      s0_col  <= col;
      s0_ai   <= addr_i_in;
      s0_ak   <= addr_k_in;

      p_v[0]    <= s0_v;
      p_last[0] <= s0_last;
      p_ai[0]   <= s0_ai;
      p_ak[0]   <= s0_ak;
      for (int l = 1; l <= LEVELS; l++) begin
        p_v[l]    <= p_v[l-1];
        p_last[l] <= p_last[l-1];
        p_ai[l]   <= p_ai[l-1];
        p_ak[l]   <= p_ak[l-1];
      end
      tree_q <= tree_d;

      // With en high the held result (if any) is being drained, so out_val
      // simply follows whether a closing beat lands this edge.
      out_val <= p_v[LEVELS] && p_last[LEVELS];
      if (p_v[LEVELS]) begin
        if (p_last[LEVELS]) begin
          sum_out      <= acc + tree_sum;
          beat_cnt_out <= bc_inc;
          addr_i_out   <= p_ai[LEVELS];
          addr_k_out   <= p_ak[LEVELS];
          acc          <= '0;
          bc           <= '0;
        end else begin
          acc <= acc + tree_sum;
          bc  <= bc_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_tree_mac_accum.sv
// Directed bench for tree_mac_accum: three instances cover unsigned/signed
// 4-element binary trees and a 5-element ternary tree.
`timescale 1ns/1ps

module tb_tree_mac_accum;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_val, in_last, out_rdy;
  logic [31:0] row, col;
  logic [7:0]  addr_i, addr_k;

  logic        in_rdy, out_val;
  logic [31:0] sum_out;
  logic [7:0]  ai_out, ak_out;
  logic [15:0] bc_out;

  logic        s_in_rdy, s_out_val;
  logic [31:0] s_sum;
  logic [7:0]  s_ai, s_ak;
  logic [15:0] s_bc;

  logic        odd_in_val;
  logic [39:0] odd_row, odd_col;
  logic        o_in_rdy, o_out_val;
  logic [31:0] o_sum;
  logic [7:0]  o_ai, o_ak;
  logic [15:0] o_bc;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  tree_mac_accum #(.DATA_WIDTH(8), .DATA_LENGTH(4), .TREE_BASE(2), .ACC_WIDTH(32),
                   .ADDRESS_WIDTH_I(8), .ADDRESS_WIDTH_K(8), .SIGNED(0)) u_dut (
    .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(in_rdy), .in_last(in_last),
    .row(row), .col(col), .addr_i_in(addr_i), .addr_k_in(addr_k),
    .out_val(out_val), .out_rdy(out_rdy), .sum_out(sum_out),
    .addr_i_out(ai_out), .addr_k_out(ak_out), .beat_cnt_out(bc_out));

  tree_mac_accum #(.DATA_WIDTH(8), .DATA_LENGTH(4), .TREE_BASE(2), .ACC_WIDTH(32),
                   .ADDRESS_WIDTH_I(8), .ADDRESS_WIDTH_K(8), .SIGNED(1)) u_sgn (
    .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(s_in_rdy), .in_last(in_last),
    .row(row), .col(col), .addr_i_in(addr_i), .addr_k_in(addr_k),
    .out_val(s_out_val), .out_rdy(out_rdy), .sum_out(s_sum),
    .addr_i_out(s_ai), .addr_k_out(s_ak), .beat_cnt_out(s_bc));

  tree_mac_accum #(.DATA_WIDTH(8), .DATA_LENGTH(5), .TREE_BASE(3), .ACC_WIDTH(32),
                   .ADDRESS_WIDTH_I(8), .ADDRESS_WIDTH_K(8), .SIGNED(0)) u_odd (
    .clk(clk), .reset(reset), .in_val(odd_in_val), .in_rdy(o_in_rdy), .in_last(in_last),
    .row(odd_row), .col(odd_col), .addr_i_in(addr_i), .addr_k_in(addr_k),
    .out_val(o_out_val), .out_rdy(out_rdy), .sum_out(o_sum),
    .addr_i_out(o_ai), .addr_k_out(o_ak), .beat_cnt_out(o_bc));

  function automatic logic [31:0] fill(input logic [7:0] v);
    return {4{v}};
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; in_val = 1'b0; odd_in_val = 1'b0; in_last = 1'b0; out_rdy = 1'b1;
    row = '0; col = '0; odd_row = '0; odd_col = '0; addr_i = '0; addr_k = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    cycle();
    n_checks++;
    if (out_val !== 1'b0 || s_out_val !== 1'b0 || o_out_val !== 1'b0)
      $display("FAIL rst_out_val: got %b/%b/%b want 0/0/0", out_val, s_out_val, o_out_val);
    else n_pass++;
    n_checks++;
    if (sum_out !== 32'd0) $display("FAIL rst_sum: got %0h want 0", sum_out);
    else n_pass++;
    n_checks++;
    if (bc_out !== 16'd0) $display("FAIL rst_beat_cnt: got %0d want 0", bc_out);
    else n_pass++;
    n_checks++;
    if (ai_out !== 8'd0 || ak_out !== 8'd0)
      $display("FAIL rst_addr: got %0h/%0h want 0/0", ai_out, ak_out);
    else n_pass++;
    n_checks++;
    if (in_rdy !== 1'b1) $display("FAIL rst_in_rdy: got %b want 1", in_rdy);
    else n_pass++;
  endtask

  // row = {4,3,2,1}, col = {8,7,6,5}: 32+21+12+5 = 70, visible after edge N+4.
  task automatic test_unsigned_single();
    row = {8'd4, 8'd3, 8'd2, 8'd1};
    col = {8'd8, 8'd7, 8'd6, 8'd5};
    in_last = 1'b1; addr_i = 8'd3; addr_k = 8'd9; in_val = 1'b1;
    cycle();
    in_val = 1'b0; in_last = 1'b0;
    repeat (3) cycle();
    n_checks++;
    if (out_val !== 1'b0) $display("FAIL single_early: got out_val=%b at N+3 want 0", out_val);
    else n_pass++;
    cycle();
    n_checks++;
    if (out_val !== 1'b1) $display("FAIL single_latency: got out_val=%b at N+4 want 1", out_val);
    else n_pass++;
    n_checks++;
    if (sum_out !== 32'd70) $display("FAIL single_sum: got %0d want 70", sum_out);
    else n_pass++;
    n_checks++;
    if (bc_out !== 16'd1) $display("FAIL single_beat_cnt: got %0d want 1", bc_out);
    else n_pass++;
    n_checks++;
    if (ai_out !== 8'd3 || ak_out !== 8'd9)
      $display("FAIL single_addr: got %0d/%0d want 3/9", ai_out, ak_out);
    else n_pass++;
    cycle();
    n_checks++;
    if (out_val !== 1'b0) $display("FAIL single_drain: got out_val=%b want 0", out_val);
    else n_pass++;
  endtask

  // 0xFF * 0x02 over 4 elements: unsigned 2040, signed -8.
  task automatic test_signedness();
    row = fill(8'hFF); col = fill(8'h02);
    in_last = 1'b1; addr_i = 8'd1; addr_k = 8'd1; in_val = 1'b1;
    cycle();
    in_val = 1'b0; in_last = 1'b0;
    repeat (4) cycle();
    n_checks++;
    if (out_val !== 1'b1 || sum_out !== 32'd2040)
      $display("FAIL unsigned_sum: got val=%b sum=%0d want 1/2040", out_val, sum_out);
    else n_pass++;
    n_checks++;
    if (s_out_val !== 1'b1 || s_sum !== 32'hFFFF_FFF8)
      $display("FAIL signed_sum: got val=%b sum=%0h want 1/fffffff8", s_out_val, s_sum);
    else n_pass++;
    cycle();
  endtask

  task automatic test_multi_beat();
    int          n_res;
    logic [31:0] r_sum;
    logic [15:0] r_bc;
    logic [7:0]  r_ak;
    n_res = 0; r_sum = '0; r_bc = '0; r_ak = '0;
    row = fill(8'd1); col = fill(8'd1);
    addr_i = 8'd5; addr_k = 8'd7; in_last = 1'b0; in_val = 1'b1;
    cycle();
    cycle();
    in_last = 1'b1; addr_k = 8'd2;
    cycle();
    in_val = 1'b0; in_last = 1'b0; addr_k = 8'd0;
    for (int t = 0; t < 12; t++) begin
      cycle();
      if (out_val) begin
        if (n_res == 0) begin
          r_sum = sum_out; r_bc = bc_out; r_ak = ak_out;
        end
        n_res++;
      end
    end
    n_checks++;
    if (n_res != 1) $display("FAIL multi_count: got %0d results want 1", n_res);
    else n_pass++;
    n_checks++;
    if (r_sum !== 32'd12) $display("FAIL multi_sum: got %0d want 12", r_sum);
    else n_pass++;
    n_checks++;
    if (r_bc !== 16'd3) $display("FAIL multi_beat_cnt: got %0d want 3", r_bc);
    else n_pass++;
    n_checks++;
    if (r_ak !== 8'd2) $display("FAIL multi_addr_k: got %0d want 2", r_ak);
    else n_pass++;
  endtask

  // Eight single-beat results (beat v sums to 4v) with a 10-cycle out_rdy stall.
  task automatic test_backpressure();
    logic [31:0] got_sum [0:15];
    logic [7:0]  got_ai  [0:15];
    int          n_got;
    bit          drv_timeout, have_snap, unstable;
    logic        rdy_in_stall, val_in_stall;
    logic [31:0] snap;
    n_got = 0; drv_timeout = 1'b0; have_snap = 1'b0; unstable = 1'b0;
    rdy_in_stall = 1'b1; val_in_stall = 1'b0; snap = '0;
    out_rdy = 1'b1;
    fork
      begin
        for (int v = 1; v <= 8; v++) begin
          bit accepted;
          accepted = 1'b0;
          row = fill(8'(v)); col = fill(8'd1);
          in_last = 1'b1; addr_i = 8'(v); addr_k = 8'(8'h40 + v); in_val = 1'b1;
          for (int t = 0; t < 100 && !accepted; t++) begin
            @(negedge clk);
            if (in_rdy) accepted = 1'b1;
            @(posedge clk);
            #1;
          end
          if (!accepted) drv_timeout = 1'b1;
        end
        in_val = 1'b0; in_last = 1'b0;
      end
      begin
        for (int t = 0; t < 60; t++) begin
          @(negedge clk);
          if (out_val && out_rdy && n_got < 16) begin
            got_sum[n_got] = sum_out;
            got_ai[n_got]  = ai_out;
            n_got++;
          end
          if (!out_rdy && out_val) begin
            if (!have_snap) begin
              snap = sum_out; have_snap = 1'b1;
            end else if (sum_out !== snap) unstable = 1'b1;
          end
          if (t == 12) begin
            rdy_in_stall = in_rdy; val_in_stall = out_val;
          end
          @(posedge clk);
          #1;
          if (t == 3)  out_rdy = 1'b0;
          if (t == 13) out_rdy = 1'b1;
        end
      end
    join
    n_checks++;
    if (drv_timeout) $display("FAIL bp_accept: got driver timeout want all beats accepted");
    else n_pass++;
    n_checks++;
    if (rdy_in_stall !== 1'b0 || val_in_stall !== 1'b1)
      $display("FAIL bp_stall: got in_rdy=%b out_val=%b want 0/1", rdy_in_stall, val_in_stall);
    else n_pass++;
    n_checks++;
    if (!have_snap || unstable)
      $display("FAIL bp_stable: got seen=%b changed=%b want 1/0", have_snap, unstable);
    else n_pass++;
    n_checks++;
    if (n_got != 8) $display("FAIL bp_count: got %0d results want 8", n_got);
    else n_pass++;
    for (int i = 0; i < 8 && i < n_got; i++) begin
      n_checks++;
      if (got_sum[i] !== 32'(4 * (i + 1)) || got_ai[i] !== 8'(i + 1))
        $display("FAIL bp_result%0d: got sum=%0d ai=%0d want %0d/%0d",
                 i, got_sum[i], got_ai[i], 4 * (i + 1), i + 1);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    found = 1'b0;
    out_rdy = 1'b1;
    row = fill(8'd1); col = fill(8'd1);
    addr_i = 8'd6; addr_k = 8'd6; in_last = 1'b0; in_val = 1'b1;
    cycle();
    cycle();
    in_val = 1'b0;
    cycle();
    reset = 1'b0;
    #1;
    n_checks++;
    if (out_val !== 1'b0 || in_rdy !== 1'b1)
      $display("FAIL mid_rst_state: got out_val=%b in_rdy=%b want 0/1", out_val, in_rdy);
    else n_pass++;
    cycle();
    cycle();
    reset = 1'b1;
    cycle();
    in_last = 1'b1; addr_i = 8'd4; in_val = 1'b1;
    cycle();
    in_val = 1'b0; in_last = 1'b0;
    for (int t = 0; t < 10 && !found; t++) begin
      cycle();
      if (out_val) found = 1'b1;
    end
    n_checks++;
    if (!found) $display("FAIL mid_rst_timeout: got no result want one");
    else n_pass++;
    n_checks++;
    if (sum_out !== 32'd4 || bc_out !== 16'd1)
      $display("FAIL mid_rst_result: got sum=%0d cnt=%0d want 4/1", sum_out, bc_out);
    else n_pass++;
    cycle();
  endtask

  // 5 elements on a base-3 tree: LEVELS=2, latency 4 edges, 1+2+3+4+5 = 15.
  task automatic test_odd_geometry();
    odd_row = {8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    odd_col = {5{8'd1}};
    out_rdy = 1'b1; in_last = 1'b1; addr_i = 8'hA; addr_k = 8'hB; odd_in_val = 1'b1;
    cycle();
    odd_in_val = 1'b0; in_last = 1'b0;
    repeat (3) cycle();
    n_checks++;
    if (o_out_val !== 1'b0) $display("FAIL odd_early: got out_val=%b at N+3 want 0", o_out_val);
    else n_pass++;
    cycle();
    n_checks++;
    if (o_out_val !== 1'b1) $display("FAIL odd_latency: got out_val=%b at N+4 want 1", o_out_val);
    else n_pass++;
    n_checks++;
    if (o_sum !== 32'd15 || o_bc !== 16'd1 || o_ai !== 8'hA)
      $display("FAIL odd_result: got sum=%0d cnt=%0d ai=%0h want 15/1/a", o_sum, o_bc, o_ai);
    else n_pass++;
    cycle();
  endtask

  initial begin
    test_reset();
    test_unsigned_single();
    test_signedness();
    test_multi_beat();
    test_backpressure();
    test_reset_mid();
    test_odd_geometry();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
